// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite responder backed by a word-addressed RAM.
// Write and read channels are independent, one outstanding transaction each,
// with an optional fixed number of wait cycles before each response.
module axi4_lite_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int RESP_DELAY = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int                    IDX_W       = $clog2(MEM_DEPTH);
    localparam int                    STRB_W      = DATA_WIDTH / 8;
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;
    localparam logic [ADDR_WIDTH:0]   MEM_BYTES   = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);
    // Counter preload: the delay state is occupied for exactly RESP_DELAY cycles
    localparam logic [3:0]            DLY_LOAD    = (RESP_DELAY > 0) ? 4'(RESP_DELAY - 1) : 4'd0;

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_WAIT_AW = 3'd1,
        W_WAIT_W  = 3'd2,
        W_DELAY   = 3'd3,
        W_RESP    = 3'd4
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DELAY = 2'd1,
        R_RESP  = 2'd2
    } r_state_t;

    // Byte address is in range when it falls inside the RAM footprint
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < MEM_BYTES);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Write channel state
    w_state_t              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [STRB_W-1:0]     w_strb_q,  w_strb_d;
    logic [3:0]            w_cnt_q,   w_cnt_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;

    // Read channel state
    r_state_t              r_state_q, r_state_d;
    logic [3:0]            r_cnt_q,   r_cnt_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;

    // Commit path
    logic                  commit_s;
    logic [ADDR_WIDTH-1:0] c_addr_s;
    logic [DATA_WIDTH-1:0] c_data_s;
    logic [STRB_W-1:0]     c_strb_s;
    logic [IDX_W-1:0]      c_idx_s;
    logic                  mem_we_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic [IDX_W-1:0]      ar_idx_s;

    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic unused_prot_s;

    assign aw_hs_s = s_axi_awvalid && awready_q;
    assign w_hs_s  = s_axi_wvalid  && wready_q;
    assign b_hs_s  = s_axi_bready  && bvalid_q;
    assign ar_hs_s = s_axi_arvalid && arready_q;
    assign r_hs_s  = s_axi_rready  && rvalid_q;

    assign unused_prot_s = ^{s_axi_awprot, s_axi_arprot};

    assign c_idx_s  = c_addr_s[IDX_W+1:2];
    assign ar_idx_s = s_axi_araddr[IDX_W+1:2];
    assign mem_we_s = commit_s && addr_in_range(c_addr_s);

    // Write FSM: collect AW and W in either order, commit on the last one, then respond
    always_comb begin
        w_state_d = w_state_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        w_cnt_d   = w_cnt_q;
        bresp_d   = bresp_q;
        commit_s  = 1'b0;
        c_addr_s  = aw_addr_q;
        c_data_s  = w_data_q;
        c_strb_s  = w_strb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    commit_s = 1'b1;
                    c_addr_s = s_axi_awaddr;
                    c_data_s = s_axi_wdata;
                    c_strb_s = s_axi_wstrb;
                end else if (aw_hs_s) begin
                    aw_addr_d = s_axi_awaddr;
                    w_state_d = W_WAIT_W;
                end else if (w_hs_s) begin
                    w_data_d  = s_axi_wdata;
                    w_strb_d  = s_axi_wstrb;
                    w_state_d = W_WAIT_AW;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_WAIT_W: begin
                if (w_hs_s) begin
                    commit_s = 1'b1;
                    c_data_s = s_axi_wdata;
                    c_strb_s = s_axi_wstrb;
                end else begin
                    w_state_d = W_WAIT_W;
                end
            end
            W_WAIT_AW: begin
                if (aw_hs_s) begin
                    commit_s = 1'b1;
                    c_addr_s = s_axi_awaddr;
                end else begin
                    w_state_d = W_WAIT_AW;
                end
            end
            W_DELAY: begin
                if (w_cnt_q == 4'd0) begin
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
        if (commit_s) begin
            bresp_d   = addr_in_range(c_addr_s) ? RESP_OKAY : RESP_SLVERR;
            w_cnt_d   = DLY_LOAD;
            w_state_d = (RESP_DELAY > 0) ? W_DELAY : W_RESP;
        end else begin
            bresp_d = bresp_q;
        end
        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_AW);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_W);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Merge strobed bytes of the committed beat into the current RAM word
    always_comb begin
        mem_wdata_s = mem[c_idx_s];
        for (int b = 0; b < STRB_W; b++) begin
            if (c_strb_s[b]) begin
                mem_wdata_s[8*b +: 8] = c_data_s[8*b +: 8];
            end else begin
                mem_wdata_s[8*b +: 8] = mem[c_idx_s][8*b +: 8];
            end
        end
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[c_idx_s] <= mem_wdata_s;
        end
    end

    // Read FSM: sample RAM at the AR handshake (pre-write data on collision), then respond
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    if (addr_in_range(s_axi_araddr)) begin
                        rdata_d = mem[ar_idx_s];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = {DATA_WIDTH{1'b0}};
                        rresp_d = RESP_SLVERR;
                    end
                    r_cnt_d   = DLY_LOAD;
                    r_state_d = (RESP_DELAY > 0) ? R_DELAY : R_RESP;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DELAY: begin
                if (r_cnt_q == 4'd0) begin
                    r_state_d = R_RESP;
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (r_hs_s) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_RESP;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_RESP);
    end

    // Write channel registers, outputs included
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state_q <= W_IDLE;
            aw_addr_q <= {ADDR_WIDTH{1'b0}};
            w_data_q  <= {DATA_WIDTH{1'b0}};
            w_strb_q  <= {STRB_W{1'b0}};
            w_cnt_q   <= 4'd0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            w_cnt_q   <= w_cnt_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Read channel registers, outputs included
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= 4'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Self-checking bench: a zero-delay instance checked against a word-array
// memory model, plus a RESP_DELAY=3 instance for latency and reset cases.
module tb_axi4_lite_slave_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [1024];

    // Zero-delay instance signals
    logic        reset_n;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    // Delayed instance signals
    logic        dd_reset_n;
    logic [31:0] dd_awaddr, dd_wdata, dd_araddr, dd_rdata;
    logic [3:0]  dd_wstrb;
    logic        dd_awvalid, dd_awready, dd_wvalid, dd_wready, dd_bvalid, dd_bready;
    logic        dd_arvalid, dd_arready, dd_rvalid, dd_rready;
    logic [1:0]  dd_bresp, dd_rresp;

    axi4_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .RESP_DELAY(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    axi4_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .RESP_DELAY(3)) dut_dly (
        .clk(clk), .reset_n(dd_reset_n),
        .s_axi_awaddr(dd_awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(dd_awvalid), .s_axi_awready(dd_awready),
        .s_axi_wdata(dd_wdata), .s_axi_wstrb(dd_wstrb), .s_axi_wvalid(dd_wvalid), .s_axi_wready(dd_wready),
        .s_axi_bresp(dd_bresp), .s_axi_bvalid(dd_bvalid), .s_axi_bready(dd_bready),
        .s_axi_araddr(dd_araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(dd_arvalid), .s_axi_arready(dd_arready),
        .s_axi_rdata(dd_rdata), .s_axi_rresp(dd_rresp), .s_axi_rvalid(dd_rvalid), .s_axi_rready(dd_rready)
    );

    // Model: in range below 4 KiB, bytes with strobe set are replaced
    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return (a < 32'h1000) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [9:0] idx;
        idx = a[11:2];
        if (a < 32'h1000) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string nm);
        int n;
        logic [1:0] er;
        er = exp_resp(a);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!(awready === 1'b1 && wready === 1'b1) && n < 20) begin @(posedge clk); #1; n++; end
        total++;
        if (n >= 20) begin bad++; $display("FAIL %s_handshake timeout awready=%b wready=%b", nm, awready, wready); end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(a, d, s);
        total++;
        if (bvalid !== 1'b1 || bresp !== er) begin
            bad++; $display("FAIL %s_bresp got bvalid=%b bresp=%b want bvalid=1 bresp=%b", nm, bvalid, bresp, er);
        end
        @(posedge clk); #1;
        bready = 1'b0;
        total++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            bad++; $display("FAIL %s_after_b got bvalid=%b awready=%b wready=%b want 0 1 1", nm, bvalid, awready, wready);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input string nm, output logic [31:0] rd);
        int n;
        logic [31:0] ed;
        ed = (a < 32'h1000) ? model[a[11:2]] : 32'h0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        total++;
        if (n >= 20) begin bad++; $display("FAIL %s_handshake timeout arready=%b", nm, arready); end
        @(posedge clk); #1;
        arvalid = 1'b0;
        rd = rdata;
        total++;
        if (rvalid !== 1'b1 || rdata !== ed || rresp !== exp_resp(a)) begin
            bad++; $display("FAIL %s got rvalid=%b rdata=%h rresp=%b want 1 %h %b", nm, rvalid, rdata, rresp, ed, exp_resp(a));
        end
        @(posedge clk); #1;
        rready = 1'b0;
        total++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            bad++; $display("FAIL %s_after_r got rvalid=%b arready=%b want 0 1", nm, rvalid, arready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; dd_reset_n = 1'b0;
        awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = 32'h0; arvalid = 1'b0; rready = 1'b0;
        dd_awaddr = 32'h0; dd_wdata = 32'h0; dd_wstrb = 4'h0; dd_awvalid = 1'b0; dd_wvalid = 1'b0; dd_bready = 1'b0;
        dd_araddr = 32'h0; dd_arvalid = 1'b0; dd_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
            bad++; $display("FAIL reset_values got rdy/vld=%b%b%b%b%b bresp=%b rresp=%b rdata=%h want all 0",
                            awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
        end
        reset_n = 1'b1; dd_reset_n = 1'b1;
        #1;
        total++;
        if ({awready, wready, arready} !== 3'b000) begin
            bad++; $display("FAIL reset_release_early got readies=%b%b%b want 000", awready, wready, arready);
        end
        @(posedge clk); #1;
        total++;
        if ({awready, wready, arready, dd_awready, dd_wready, dd_arready} !== 6'b111111) begin
            bad++; $display("FAIL reset_release_ready got %b%b%b %b%b%b want all 1",
                            awready, wready, arready, dd_awready, dd_wready, dd_arready);
        end
    endtask

    task automatic test_preload();
        for (int i = 0; i < 64; i++) do_write(32'(i * 4), $urandom, 4'hF, "preload");
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        do_write(32'h10, 32'hDEADBEEF, 4'hF, "basic_wr");
        do_read(32'h10, "basic_rd", rd);
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_const got %h want deadbeef", rd); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        do_write(32'h20, 32'h11223344, 4'hF, "strb_pre");
        do_write(32'h20, 32'hAABBCCDD, 4'b0101, "strb_wr");
        do_read(32'h20, "strb_rd", rd);
        total++;
        if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strb_const got %h want 11bb33dd", rd); end
        do_write(32'h20, 32'hFFFFFFFF, 4'h0, "strb_zero_wr");
        do_read(32'h20, "strb_zero_rd", rd);
    endtask

    task automatic test_w_before_aw();
        logic [31:0] rd;
        do_write(32'h30, 32'h0BADF00D, 4'hF, "wfirst_pre");
        wdata = 32'h600DCAFE; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        wvalid = 1'b0;
        total++;
        if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            bad++; $display("FAIL wfirst_latched got wready=%b awready=%b bvalid=%b want 0 1 0", wready, awready, bvalid);
        end
        do_read(32'h30, "wfirst_not_committed", rd);
        awaddr = 32'h30; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        model_write(32'h30, 32'h600DCAFE, 4'hF);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
                bad++; $display("FAIL wfirst_hold cyc=%0d got bvalid=%b bresp=%b awready=%b wready=%b want 1 00 0 0",
                                k, bvalid, bresp, awready, wready);
            end
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        total++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            bad++; $display("FAIL wfirst_release got bvalid=%b awready=%b wready=%b want 0 1 1", bvalid, awready, wready);
        end
        do_read(32'h30, "wfirst_committed", rd);
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        do_write(32'h0, 32'h13579BDF, 4'hF, "oor_word0");
        do_write(32'h1000, 32'hFFFFFFFF, 4'hF, "oor_wr");
        do_read(32'h1000, "oor_rd", rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL oor_rdata got %h want 0", rd); end
        do_read(32'h0, "oor_word0_rd", rd);
        total++;
        if (rd !== 32'h13579BDF) begin bad++; $display("FAIL oor_word0_const got %h want 13579bdf", rd); end
    endtask

    task automatic test_collision();
        logic [31:0] rd;
        do_write(32'h8, 32'h5, 4'hF, "coll_pre");
        araddr = 32'h8; arvalid = 1'b1; rready = 1'b1;
        awaddr = 32'h8; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'h5 || rresp !== 2'b00 || bvalid !== 1'b1 || bresp !== 2'b00) begin
            bad++; $display("FAIL collision got rvalid=%b rdata=%h rresp=%b bvalid=%b bresp=%b want 1 5 00 1 00",
                            rvalid, rdata, rresp, bvalid, bresp);
        end
        model_write(32'h8, 32'h9, 4'hF);
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        do_read(32'h8, "coll_after", rd);
        total++;
        if (rd !== 32'h9) begin bad++; $display("FAIL coll_after_const got %h want 9", rd); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        awaddr = 32'hC8; wdata = 32'h5555AAAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bvalid === 1'b1) cnt++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(32'hC8, 32'h5555AAAA, 4'hF);
        total++;
        if (cnt !== 4) begin bad++; $display("FAIL b2b_write got %0d responses want 4", cnt); end
        @(posedge clk); #1;
        bready = 1'b0;
        araddr = 32'hC8; arvalid = 1'b1; rready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rvalid === 1'b1) begin
                cnt++;
                total++;
                if (rdata !== 32'h5555AAAA) begin bad++; $display("FAIL b2b_rdata got %h want 5555aaaa", rdata); end
            end
        end
        arvalid = 1'b0;
        total++;
        if (cnt !== 4) begin bad++; $display("FAIL b2b_read got %0d responses want 4", cnt); end
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a, rd;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                a = {20'h0, 4'($urandom_range(0, 15)) & 4'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            end else begin
                a = $urandom;
                if (a < 32'h1000) a = a + 32'h1000;
            end
            if ($urandom_range(0, 1) == 0) do_write(a, $urandom, 4'($urandom_range(0, 15)), "rand_wr");
            else do_read(a, "rand_rd", rd);
        end
    endtask

    task automatic dd_read(input logic [31:0] a, input logic [31:0] ed, input string nm);
        int n;
        dd_araddr = a; dd_arvalid = 1'b1; dd_rready = 1'b1;
        @(posedge clk); #1;
        dd_arvalid = 1'b0;
        n = 1;
        while (dd_rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        total++;
        if (n !== 4 || dd_rdata !== ed || dd_rresp !== 2'b00) begin
            bad++; $display("FAIL %s got latency=%0d rdata=%h rresp=%b want 4 %h 00", nm, n, dd_rdata, dd_rresp, ed);
        end
        @(posedge clk); #1;
        dd_rready = 1'b0;
    endtask

    task automatic test_delay_and_reset();
        dd_awaddr = 32'h40; dd_wdata = 32'hCAFE0001; dd_wstrb = 4'hF; dd_awvalid = 1'b1; dd_wvalid = 1'b1; dd_bready = 1'b1;
        @(posedge clk); #1;
        dd_awvalid = 1'b0; dd_wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (dd_bvalid !== 1'b0) begin bad++; $display("FAIL dly_bvalid_early cyc=%0d got 1 want 0", k); end
            @(posedge clk); #1;
        end
        total++;
        if (dd_bvalid !== 1'b1 || dd_bresp !== 2'b00) begin
            bad++; $display("FAIL dly_bvalid got bvalid=%b bresp=%b want 1 00", dd_bvalid, dd_bresp);
        end
        @(posedge clk); #1;
        dd_bready = 1'b0;
        dd_read(32'h40, 32'hCAFE0001, "dly_read");
        // write and read in flight, then reset while both sit in their delay states
        dd_awaddr = 32'h44; dd_wdata = 32'h77665544; dd_awvalid = 1'b1; dd_wvalid = 1'b1; dd_bready = 1'b1;
        dd_araddr = 32'h40; dd_arvalid = 1'b1; dd_rready = 1'b1;
        @(posedge clk); #1;
        dd_awvalid = 1'b0; dd_wvalid = 1'b0; dd_arvalid = 1'b0;
        @(posedge clk); #1;
        dd_reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if ({dd_awready, dd_wready, dd_arready, dd_bvalid, dd_rvalid} !== 5'b0) begin
                bad++; $display("FAIL dly_in_reset cyc=%0d got rdy=%b%b%b bvalid=%b rvalid=%b want all 0",
                                k, dd_awready, dd_wready, dd_arready, dd_bvalid, dd_rvalid);
            end
            @(posedge clk); #1;
        end
        dd_reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({dd_awready, dd_wready, dd_arready} !== 3'b111) begin
            bad++; $display("FAIL dly_release got readies=%b%b%b want 111", dd_awready, dd_wready, dd_arready);
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (dd_bvalid !== 1'b0 || dd_rvalid !== 1'b0) begin
                bad++; $display("FAIL dly_abandoned cyc=%0d got bvalid=%b rvalid=%b want 0 0", k, dd_bvalid, dd_rvalid);
            end
            @(posedge clk); #1;
        end
        dd_bready = 1'b0; dd_rready = 1'b0;
        dd_read(32'h44, 32'h77665544, "dly_committed_kept");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_preload();
        test_basic();
        test_strobe();
        test_w_before_aw();
        test_out_of_range();
        test_collision();
        test_back_to_back();
        test_random();
        test_delay_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
